// File: rtl/soc_apb_periph_demux.sv
// ----------------------------------------------------------------------------
// soc_apb_periph_demux
//
// APB peripheral demultiplexer. It sits downstream of the AXI-Lite-to-APB
// bridge, decodes each upstream APB transfer onto one of NR_SLAVES peripheral
// ports, and re-issues it there with registered setup/access phases. Every
// downstream access has a pready timeout, so a hung peripheral cannot stall
// the interconnect. Unmapped addresses and timeouts are completed upstream
// with pslverr and a recognisable read-data pattern.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for an upstream setup phase (psel_i=1, penable_i=0)
// DN_SETUP  | downstream setup phase, psel_o[idx]=1, penable_o=0
// DN_ACCESS | downstream access phase, waiting on pready_i[idx] or timeout
// RESP      | one-cycle upstream completion, pready_o=1
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   paddr_i/pwdata_i/pwrite_i     upstream transfer attributes
//   psel_i/penable_i              upstream handshake
//   prdata_o/pready_o/pslverr_o   upstream response (non-zero only in RESP)
//   paddr_o/pwdata_o/pwrite_o     shared registered downstream attributes
//   psel_o/penable_o              one-hot downstream select, shared enable
//   prdata_i/pready_i/pslverr_i   per-slave downstream response, packed
//   decode_err_o/timeout_o        one-cycle event pulses, aligned with RESP
// ----------------------------------------------------------------------------
module soc_apb_periph_demux #(
    parameter int unsigned                      NR_SLAVES      = 8,
    parameter int unsigned                      ADDR_WIDTH     = 32,
    parameter int unsigned                      DATA_WIDTH     = 32,
    parameter logic [NR_SLAVES*ADDR_WIDTH-1:0]  START_ADDR     = '0,
    parameter logic [NR_SLAVES*ADDR_WIDTH-1:0]  END_ADDR       = '0,
    parameter int unsigned                      TIMEOUT_CYCLES = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [ADDR_WIDTH-1:0]           paddr_i,
    input  logic [DATA_WIDTH-1:0]           pwdata_i,
    input  logic                            pwrite_i,
    input  logic                            psel_i,
    input  logic                            penable_i,
    output logic [DATA_WIDTH-1:0]           prdata_o,
    output logic                            pready_o,
    output logic                            pslverr_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    output logic [DATA_WIDTH-1:0]           pwdata_o,
    output logic                            pwrite_o,
    output logic [NR_SLAVES-1:0]            psel_o,
    output logic                            penable_o,
    input  logic [NR_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NR_SLAVES-1:0]            pready_i,
    input  logic [NR_SLAVES-1:0]            pslverr_i,
    output logic                            decode_err_o,
    output logic                            timeout_o
);

    localparam int unsigned IDX_W = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
    // A zero timeout still needs a legal one-bit counter; it is simply never compared.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] RDATA_DECERR  = DATA_WIDTH'(32'hBADACCE5);
    localparam logic [DATA_WIDTH-1:0] RDATA_TIMEOUT = DATA_WIDTH'(32'h0BADC0DE);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DN_SETUP  = 2'd1,
        DN_ACCESS = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dec_err_q, dec_err_d;
    logic                    timeout_q, timeout_d;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;

    // Scan from the top so the lowest matching rule is the last assignment.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(NR_SLAVES) - 1; i >= 0; i--) begin
            if ((paddr_i >= START_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                (paddr_i <  END_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = pready_i[idx_q];
        sel_err   = pslverr_i[idx_q];
        sel_rdata = prdata_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        idx_d     = idx_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        dec_err_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    idx_d   = dec_idx;
                    if (dec_hit) begin
                        state_d = DN_SETUP;
                    end else begin
                        state_d   = RESP;
                        err_d     = 1'b1;
                        rdata_d   = RDATA_DECERR;
                        dec_err_d = 1'b1;
                    end
                end
            end

            DN_SETUP: begin
                state_d = DN_ACCESS;
                cnt_d   = '0;
            end

            DN_ACCESS: begin
                if (sel_ready) begin
                    state_d = RESP;
                    err_d   = sel_err;
                    rdata_d = write_q ? '0 : sel_rdata;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rdata_d   = RDATA_TIMEOUT;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            dec_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            dec_err_q <= dec_err_d;
            timeout_q <= timeout_d;
        end
    end

    logic in_dn;
    logic in_resp;

    always_comb begin
        in_dn        = (state_q == DN_SETUP) || (state_q == DN_ACCESS);
        in_resp      = (state_q == RESP);
        psel_o       = in_dn ? (NR_SLAVES'(1) << idx_q) : '0;
        penable_o    = (state_q == DN_ACCESS);
        paddr_o      = addr_q;
        pwdata_o     = wdata_q;
        pwrite_o     = write_q;
        pready_o     = in_resp;
        pslverr_o    = in_resp & err_q;
        prdata_o     = in_resp ? rdata_q : '0;
        decode_err_o = dec_err_q;
        timeout_o    = timeout_q;
    end

endmodule

// File: tb/tb_soc_apb_periph_demux.sv
module tb_soc_apb_periph_demux;

    localparam int NR = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [NR*AW-1:0] START = {32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h1A100800, 32'h1A102000, 32'h1A104000, 32'h1A100000};
    localparam logic [NR*AW-1:0] ENDA  = {32'h0, 32'h0, 32'h0, 32'h0,
                                          32'h1A101800, 32'h1A103000, 32'h1A105000, 32'h1A101000};

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pwrite;
    logic            psel;
    logic            penable;
    logic [DW-1:0]   prdata_o;
    logic            pready_o;
    logic            pslverr_o;
    logic [AW-1:0]   paddr_o;
    logic [DW-1:0]   pwdata_o;
    logic            pwrite_o;
    logic [NR-1:0]   psel_o;
    logic            penable_o;
    logic [NR*DW-1:0] prdata_i;
    logic [NR-1:0]   pready_i;
    logic [NR-1:0]   pslverr_i;
    logic            decode_err_o;
    logic            timeout_o;

    soc_apb_periph_demux #(
        .NR_SLAVES      (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .START_ADDR     (START),
        .END_ADDR       (ENDA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .pwrite_i     (pwrite),
        .psel_i       (psel),
        .penable_i    (penable),
        .prdata_o     (prdata_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pwrite_o     (pwrite_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .prdata_i     (prdata_i),
        .pready_i     (pready_i),
        .pslverr_i    (pslverr_i),
        .decode_err_o (decode_err_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral models: each slave has a wait-state count, a hang flag,
    // fixed read data and an error flag.
    int          slv_wait  [NR];
    bit          slv_hang  [NR];
    bit          slv_err   [NR];
    logic [31:0] slv_rdata [NR];
    int          wcnt = 0;

    always @(posedge clk) begin
        if ((|psel_o) && penable_o && !(|(pready_i & psel_o)))
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    always_comb begin
        pready_i  = '0;
        pslverr_i = '0;
        prdata_i  = '0;
        for (int i = 0; i < NR; i++) begin
            pready_i[i]           = psel_o[i] & penable_o & !slv_hang[i] & (wcnt >= slv_wait[i]);
            pslverr_i[i]          = slv_err[i];
            prdata_i[i*DW +: DW]  = slv_rdata[i];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One upstream transfer. Expected response goes to the scoreboard when the
    // transfer is driven; it is popped when pready_o is seen.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic wr, input logic [31:0] er, input logic ee,
                        input int elat, input logic [7:0] esel, input int epen,
                        input int ederr, input int eto);
        resp_t      r;
        resp_t      got_r;
        bit         got;
        int         start_cyc;
        logic [7:0] sel_acc;
        int         pen_cnt, derr_cnt, to_cnt;
        r.rdata = er; r.err = ee; r.lat = elat;
        exp_q.push_back(r);
        @(posedge clk); #1;
        start_cyc = cyc;
        sel_acc = '0; pen_cnt = 0; derr_cnt = 0; to_cnt = 0; got = 0;
        paddr = a; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            sel_acc  |= psel_o;
            pen_cnt  += int'(penable_o);
            derr_cnt += int'(decode_err_o);
            to_cnt   += int'(timeout_o);
            if (pready_o) begin
                got = 1;
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_resp"}, 64'd1, 64'd0);
                end else begin
                    got_r = exp_q.pop_front();
                    check({tag, "_prdata"},  64'(prdata_o),  64'(got_r.rdata));
                    check({tag, "_pslverr"}, 64'(pslverr_o), 64'(got_r.err));
                    check({tag, "_latency"}, 64'(cyc - start_cyc + 1), 64'(got_r.lat));
                end
            end
        end
        check({tag, "_resp_seen"}, 64'(got), 64'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check({tag, "_psel_o"},     64'(sel_acc),  64'(esel));
        check({tag, "_penable_n"},  64'(pen_cnt),  64'(epen));
        check({tag, "_decode_err"}, 64'(derr_cnt), 64'(ederr));
        check({tag, "_timeout"},    64'(to_cnt),   64'(eto));
        if (esel != 8'h00) begin
            check({tag, "_paddr_o"},  64'(paddr_o),  64'(a));
            check({tag, "_pwdata_o"}, 64'(pwdata_o), 64'(wd));
            check({tag, "_pwrite_o"}, 64'(pwrite_o), 64'(wr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr_wdata"}, {paddr_o, pwdata_o}, 64'd0);
        check({tag, "_prdata"}, 64'(prdata_o), 64'd0);
        check({tag, "_ctrl"}, 64'({pwrite_o, psel_o, penable_o, pready_o, pslverr_o,
                                   decode_err_o, timeout_o}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            slv_wait[i]  = 0;
            slv_hang[i]  = 1'b0;
            slv_err[i]   = 1'b0;
            slv_rdata[i] = 32'hA0000000 + 32'(i);
        end
        slv_rdata[2] = 32'h12345678;
        rst_n = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        xfer("rd_s2", 32'h1A102010, 32'h0, 1'b0, 32'h12345678, 1'b0, 4, 8'h04, 1, 0, 0);
        slv_wait[2] = 3;
        xfer("wr_s2_wait3", 32'h1A102004, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 7, 8'h04, 4, 0, 0);
        slv_wait[2] = 0;
        xfer("unmapped", 32'h00000000, 32'h0, 1'b0, 32'hBADACCE5, 1'b1, 2, 8'h00, 0, 1, 0);

        slv_hang[2] = 1'b1;
        xfer("timeout", 32'h1A102100, 32'h0, 1'b0, 32'h0BADC0DE, 1'b1, 3 + TO, 8'h04, TO, 0, 1);
        slv_hang[2] = 1'b0;
        slv_wait[2] = 1;
        xfer("after_to", 32'h1A102200, 32'h0, 1'b0, 32'h12345678, 1'b0, 5, 8'h04, 2, 0, 0);
        slv_wait[2] = 0;

        xfer("overlap", 32'h1A100900, 32'h0, 1'b0, 32'hA0000000, 1'b0, 4, 8'h01, 1, 0, 0);
        xfer("rule3_only", 32'h1A101100, 32'h0, 1'b0, 32'hA0000003, 1'b0, 4, 8'h08, 1, 0, 0);
        xfer("start_incl", 32'h1A102000, 32'h0, 1'b0, 32'h12345678, 1'b0, 4, 8'h04, 1, 0, 0);
        xfer("end_excl", 32'h1A103000, 32'h0, 1'b0, 32'hBADACCE5, 1'b1, 2, 8'h00, 0, 1, 0);
        slv_err[1] = 1'b1;
        xfer("slverr_s1", 32'h1A104FFC, 32'h0, 1'b0, 32'hA0000001, 1'b1, 4, 8'h02, 1, 0, 0);
        slv_err[1] = 1'b0;

        // Reset while the downstream access is stalled on a hung slave.
        slv_hang[2] = 1'b1;
        @(posedge clk); #1;
        paddr = 32'h1A102020; pwdata = 32'h55AA55AA; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_in_access", 64'({psel_o, penable_o}), 64'({8'h04, 1'b1}));
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        slv_hang[2] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("rst_mid_no_pready", 64'(pready_o), 64'd0);
        end

        xfer("post_rst", 32'h1A102030, 32'h0, 1'b0, 32'h12345678, 1'b0, 4, 8'h04, 1, 0, 0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
